// File: rtl/c1_pad_scan_if.sv
// -----------------------------------------------------------------------------
// c1_pad_scan_if
// Signal bundle between the two pad connectors, the 68k input-zone decode and
// the C1 pad scanner.
//
//   nCTRL1_ZONE / nCTRL2_ZONE / nSTATUSB_ZONE : active-low 68k zone reads
//   PAD1_DATA / PAD2_DATA : serial pad data (0 = pressed), asynchronous
//   PAD_LATCH             : parallel-load strobe to both pads, active high
//   PAD_CLK               : shift clock to both pads, idle high
//   P1_IN / P2_IN         : committed pad state, active low
//   SCAN_DONE             : one-cycle pulse on each commit
//   BUSY                  : scanner FSM is not idle
//
// Modports:
//   slave  - the scanner (reads zones/pad data, drives the rest)
//   master - the surroundings (pads, bus decode, C1 input read)
// -----------------------------------------------------------------------------
interface c1_pad_scan_if;
    logic       nCTRL1_ZONE;
    logic       nCTRL2_ZONE;
    logic       nSTATUSB_ZONE;
    logic       PAD1_DATA;
    logic       PAD2_DATA;
    logic       PAD_LATCH;
    logic       PAD_CLK;
    logic [9:0] P1_IN;
    logic [9:0] P2_IN;
    logic       SCAN_DONE;
    logic       BUSY;

    modport slave (
        input  nCTRL1_ZONE,
        input  nCTRL2_ZONE,
        input  nSTATUSB_ZONE,
        input  PAD1_DATA,
        input  PAD2_DATA,
        output PAD_LATCH,
        output PAD_CLK,
        output P1_IN,
        output P2_IN,
        output SCAN_DONE,
        output BUSY
    );

    modport master (
        output nCTRL1_ZONE,
        output nCTRL2_ZONE,
        output nSTATUSB_ZONE,
        output PAD1_DATA,
        output PAD2_DATA,
        input  PAD_LATCH,
        input  PAD_CLK,
        input  P1_IN,
        input  P2_IN,
        input  SCAN_DONE,
        input  BUSY
    );
endinterface

// File: rtl/c1_pad_scan.sv
// -----------------------------------------------------------------------------
// c1_pad_scan
// Periodic serial scanner for two player pads using a latch/clock shift
// register interface. Every SCAN_DIV cycles it latches both pads, shifts out
// PAD_BITS bits from each, and commits them as the active-low P1_IN / P2_IN
// words read by the C1 input decode. The commit is held off while the 68k is
// reading any input zone so a single bus read never sees a torn word.
//
// Ports:
//   CLK_24M  in  system clock, all state lives here
//   nRESET   in  asynchronous active-low reset
//   bus      c1_pad_scan_if.slave (zones, pad data, pad strobes, outputs)
//
// Parameters:
//   SCAN_DIV  cycles between scan starts (>= 4*BIT_DIV*PAD_BITS for 1 scan/tick)
//   BIT_DIV   cycles per PAD_CLK phase and PAD_LATCH width (>= 2)
//   PAD_BITS  bits per pad, fixed at 10 to match P*_IN
//
// Optional build macro:
//   C1_PAD_DEBOUNCE_EN - a committed bit only changes when two consecutive
//   scans agree on it; the previous raw sample is kept per pad.
// -----------------------------------------------------------------------------
module c1_pad_scan #(
    parameter int SCAN_DIV = 24000,
    parameter int BIT_DIV  = 12,
    parameter int PAD_BITS = 10
) (
    input  logic         CLK_24M,
    input  logic         nRESET,
    c1_pad_scan_if.slave bus
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(BIT_DIV);
    localparam int IW = $clog2(PAD_BITS);

    localparam logic [TW-1:0]       TIMER_LAST   = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]       PHASE_LAST   = CW'(BIT_DIV - 1);
    localparam logic [IW-1:0]       INDEX_LAST   = IW'(PAD_BITS - 1);
    localparam logic [TW-1:0]       TIMER_ZERO   = {TW{1'b0}};
    localparam logic [CW-1:0]       PHASE_ZERO   = {CW{1'b0}};
    localparam logic [IW-1:0]       INDEX_ZERO   = {IW{1'b0}};
    localparam logic [PAD_BITS-1:0] ALL_RELEASED = {PAD_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

`ifdef C1_PAD_DEBOUNCE_EN
    // Take the new bit where the new sample agrees with the previous raw
    // sample, otherwise keep the committed bit.
    function automatic logic [PAD_BITS-1:0] debounce_merge(
        input logic [PAD_BITS-1:0] committed,
        input logic [PAD_BITS-1:0] prev_raw,
        input logic [PAD_BITS-1:0] new_raw
    );
        logic [PAD_BITS-1:0] stable;
        stable = ~(new_raw ^ prev_raw);
        return (new_raw & stable) | (committed & ~stable);
    endfunction
`endif

    // Synchronizers: bit 0 carries pad 1, bit 1 carries pad 2
    logic [1:0]          sync_meta_r;
    logic [1:0]          sync_r;

    // Scan timer
    logic [TW-1:0]       timer_r;
    logic                tick_r;

    // FSM state and its sub-counters
    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       phase_cnt_r;
    logic [CW-1:0]       phase_cnt_s;
    logic                clk_high_r;     // 0 = PAD_CLK low phase of a bit, 1 = high phase
    logic                clk_high_s;
    logic [IW-1:0]       bit_idx_r;
    logic [IW-1:0]       bit_idx_s;
    logic                pending_r;
    logic                pending_s;
    logic                sample_s;
    logic                commit_s;
    logic                zone_active_s;

    // Shadow sample registers
    logic [PAD_BITS-1:0] shadow1_r;
    logic [PAD_BITS-1:0] shadow2_r;
`ifdef C1_PAD_DEBOUNCE_EN
    logic [PAD_BITS-1:0] prev1_r;
    logic [PAD_BITS-1:0] prev2_r;
`endif

    // Registered outputs
    logic [PAD_BITS-1:0] p1_r;
    logic [PAD_BITS-1:0] p2_r;
    logic                pad_latch_r;
    logic                pad_clk_r;
    logic                scan_done_r;
    logic                busy_r;

    // Any 68k read of an input zone blocks the commit.
    assign zone_active_s = ~(bus.nCTRL1_ZONE & bus.nCTRL2_ZONE & bus.nSTATUSB_ZONE);

    // Two-flop synchronizer for the asynchronous pad data lines
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            sync_meta_r <= 2'b11;
            sync_r      <= 2'b11;
        end else begin
            sync_meta_r <= {bus.PAD2_DATA, bus.PAD1_DATA};
            sync_r      <= sync_meta_r;
        end
    end

    // Free-running scan timer; the tick is registered so it lands one cycle
    // after the wrap and the scan starts the cycle after that.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            timer_r <= TIMER_ZERO;
            tick_r  <= 1'b0;
        end else if (timer_r == TIMER_LAST) begin
            timer_r <= TIMER_ZERO;
            tick_r  <= 1'b1;
        end else begin
            timer_r <= timer_r + TW'(1);
            tick_r  <= 1'b0;
        end
    end

    // FSM next-state, sub-counter and pending-request logic
    always_comb begin
        state_s     = state_r;
        phase_cnt_s = phase_cnt_r;
        clk_high_s  = clk_high_r;
        bit_idx_s   = bit_idx_r;
        pending_s   = pending_r;
        sample_s    = 1'b0;
        commit_s    = 1'b0;

        // A tick arriving mid-scan is remembered once; extra ticks fold into it.
        if (tick_r && (state_r != ST_IDLE)) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (tick_r || pending_r) begin
                    state_s     = ST_LATCH;
                    phase_cnt_s = PHASE_ZERO;
                    pending_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LATCH: begin
                if (phase_cnt_r == PHASE_LAST) begin
                    state_s     = ST_SHIFT;
                    phase_cnt_s = PHASE_ZERO;
                    clk_high_s  = 1'b0;
                    bit_idx_s   = INDEX_ZERO;
                end else begin
                    phase_cnt_s = phase_cnt_r + CW'(1);
                end
            end

            ST_SHIFT: begin
                if (phase_cnt_r == PHASE_LAST) begin
                    phase_cnt_s = PHASE_ZERO;
                    if (!clk_high_r) begin
                        // Last low-phase cycle: the pad has held this bit
                        // long enough to be through the synchronizer.
                        sample_s   = 1'b1;
                        clk_high_s = 1'b1;
                    end else begin
                        clk_high_s = 1'b0;
                        if (bit_idx_r == INDEX_LAST) begin
                            state_s = ST_COMMIT;
                        end else begin
                            bit_idx_s = bit_idx_r + IW'(1);
                        end
                    end
                end else begin
                    phase_cnt_s = phase_cnt_r + CW'(1);
                end
            end

            ST_COMMIT: begin
                if (zone_active_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    commit_s = 1'b1;
                    state_s  = ST_IDLE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register; pad strobes and BUSY are registered from the next
    // state so they line up with the state they describe.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= PHASE_ZERO;
            clk_high_r  <= 1'b0;
            bit_idx_r   <= INDEX_ZERO;
            pending_r   <= 1'b0;
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b1;
            busy_r      <= 1'b0;
            scan_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_cnt_r <= phase_cnt_s;
            clk_high_r  <= clk_high_s;
            bit_idx_r   <= bit_idx_s;
            pending_r   <= pending_s;
            pad_latch_r <= (state_s == ST_LATCH);
            pad_clk_r   <= ~((state_s == ST_SHIFT) && !clk_high_s);
            busy_r      <= (state_s != ST_IDLE);
            scan_done_r <= commit_s;
        end
    end

    // Shadow capture: shadow bit i holds the i-th bit shifted out of the pad
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            shadow1_r <= ALL_RELEASED;
            shadow2_r <= ALL_RELEASED;
        end else if (sample_s) begin
            shadow1_r[bit_idx_r] <= sync_r[0];
            shadow2_r[bit_idx_r] <= sync_r[1];
        end
    end

`ifdef C1_PAD_DEBOUNCE_EN
    // Commit with two-scan agreement; the raw history always follows the sample
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            p1_r    <= ALL_RELEASED;
            p2_r    <= ALL_RELEASED;
            prev1_r <= ALL_RELEASED;
            prev2_r <= ALL_RELEASED;
        end else if (commit_s) begin
            p1_r    <= debounce_merge(p1_r, prev1_r, shadow1_r);
            p2_r    <= debounce_merge(p2_r, prev2_r, shadow2_r);
            prev1_r <= shadow1_r;
            prev2_r <= shadow2_r;
        end
    end
`else
    // Commit copies the shadows straight into the visible words
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            p1_r <= ALL_RELEASED;
            p2_r <= ALL_RELEASED;
        end else if (commit_s) begin
            p1_r <= shadow1_r;
            p2_r <= shadow2_r;
        end
    end
`endif

    assign bus.PAD_LATCH = pad_latch_r;
    assign bus.PAD_CLK   = pad_clk_r;
    assign bus.P1_IN     = p1_r;
    assign bus.P2_IN     = p2_r;
    assign bus.SCAN_DONE = scan_done_r;
    assign bus.BUSY      = busy_r;

endmodule

// File: tb/tb_c1_pad_scan.sv
// -----------------------------------------------------------------------------
// tb_c1_pad_scan
// Directed bench for c1_pad_scan. dut uses SCAN_DIV=200, BIT_DIV=2 with a
// behavioural shift-register model of both pads; dut_b uses SCAN_DIV=40 so
// scans run back to back through the pending request.
// Edge numbering: edge 1 is the first rising CLK_24M edge after reset release.
// -----------------------------------------------------------------------------
module tb_c1_pad_scan;

`ifdef C1_PAD_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst_b_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    c1_pad_scan_if bus_a();
    c1_pad_scan_if bus_b();

    c1_pad_scan #(.SCAN_DIV(200), .BIT_DIV(2), .PAD_BITS(10)) dut (
        .CLK_24M (clk),
        .nRESET  (rst_n),
        .bus     (bus_a)
    );

    c1_pad_scan #(.SCAN_DIV(40), .BIT_DIV(2), .PAD_BITS(10)) dut_b (
        .CLK_24M (clk),
        .nRESET  (rst_b_n),
        .bus     (bus_b)
    );

    // Pad model: parallel load on PAD_LATCH, shift toward bit 0 on PAD_CLK rise
    logic [9:0] pat1 = 10'h3FF;
    logic [9:0] pat2 = 10'h3FF;
    logic [9:0] sr1  = 10'h3FF;
    logic [9:0] sr2  = 10'h3FF;

    always @(posedge bus_a.PAD_LATCH) begin
        sr1 = pat1;
        sr2 = pat2;
    end

    always @(posedge bus_a.PAD_CLK) begin
        sr1 = {1'b1, sr1[9:1]};
        sr2 = {1'b1, sr2[9:1]};
    end

    assign bus_a.PAD1_DATA = sr1[0];
    assign bus_a.PAD2_DATA = sr2[0];

    assign bus_b.nCTRL1_ZONE   = 1'b1;
    assign bus_b.nCTRL2_ZONE   = 1'b1;
    assign bus_b.nSTATUSB_ZONE = 1'b1;
    assign bus_b.PAD1_DATA     = 1'b1;
    assign bus_b.PAD2_DATA     = 1'b1;

    task automatic wait_latch(output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < 300) begin
            @(negedge clk);
            i++;
            ok = (bus_a.PAD_LATCH === 1'b1);
        end
    endtask

    task automatic wait_done(output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < 300) begin
            @(negedge clk);
            i++;
            ok = (bus_a.SCAN_DONE === 1'b1);
        end
    endtask

    task automatic set_zone(input int zone, input logic v);
        case (zone)
            1:       bus_a.nCTRL1_ZONE   = v;
            2:       bus_a.nCTRL2_ZONE   = v;
            default: bus_a.nSTATUSB_ZONE = v;
        endcase
    endtask

    // Records the timeline of one scan starting from reset release
    task automatic observe_from_release(output int first_latch, output int latch_len,
                                        output int clk_lows, output int clk_falls,
                                        output int done_at);
        logic prev_clk;
        first_latch = 0; latch_len = 0; clk_lows = 0; clk_falls = 0; done_at = 0;
        prev_clk = 1'b1;
        for (int n = 1; n <= 250; n++) begin
            @(negedge clk);
            if (bus_a.PAD_LATCH === 1'b1) begin
                latch_len++;
                if (first_latch == 0) first_latch = n;
            end
            if (bus_a.PAD_CLK === 1'b0) clk_lows++;
            if (bus_a.PAD_CLK === 1'b0 && prev_clk === 1'b1) clk_falls++;
            prev_clk = bus_a.PAD_CLK;
            if (bus_a.SCAN_DONE === 1'b1 && done_at == 0) done_at = n;
        end
    endtask

    task automatic test_reset();
        int fl, ll, cl, cf, da;
        pat1 = 10'h3FF; pat2 = 10'h3FF;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.P1_IN !== 10'h3FF) begin failures++; $display("FAIL reset_p1 got=%h exp=3ff", bus_a.P1_IN); end
        checks++; if (bus_a.P2_IN !== 10'h3FF) begin failures++; $display("FAIL reset_p2 got=%h exp=3ff", bus_a.P2_IN); end
        checks++; if (bus_a.PAD_LATCH !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b exp=0", bus_a.PAD_LATCH); end
        checks++; if (bus_a.PAD_CLK !== 1'b1) begin failures++; $display("FAIL reset_padclk got=%b exp=1", bus_a.PAD_CLK); end
        checks++; if (bus_a.SCAN_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_a.SCAN_DONE); end
        checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.BUSY); end
        rst_n = 1'b1;
        observe_from_release(fl, ll, cl, cf, da);
        checks++; if (fl != 201) begin failures++; $display("FAIL first_latch_edge got=%0d exp=201", fl); end
        checks++; if (ll != 2) begin failures++; $display("FAIL latch_width got=%0d exp=2", ll); end
        checks++; if (cf != 10) begin failures++; $display("FAIL padclk_pulses got=%0d exp=10", cf); end
        checks++; if (cl != 20) begin failures++; $display("FAIL padclk_low_cycles got=%0d exp=20", cl); end
        checks++; if (da != 244) begin failures++; $display("FAIL scan_done_edge got=%0d exp=244", da); end
        checks++; if (bus_a.P1_IN !== 10'h3FF) begin failures++; $display("FAIL idle_scan_p1 got=%h exp=3ff", bus_a.P1_IN); end
        checks++; if (bus_a.P2_IN !== 10'h3FF) begin failures++; $display("FAIL idle_scan_p2 got=%h exp=3ff", bus_a.P2_IN); end
    endtask

    task automatic test_shift();
        bit ok;
        logic [9:0] e1, e2;
        pat1 = 10'h3FE; pat2 = 10'h1FF;
        e1 = DEB ? 10'h3FF : 10'h3FE;
        e2 = DEB ? 10'h3FF : 10'h1FF;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL shift1_done_timeout got=0 exp=1"); end
        checks++; if (bus_a.P1_IN !== e1) begin failures++; $display("FAIL shift1_p1 got=%h exp=%h", bus_a.P1_IN, e1); end
        checks++; if (bus_a.P2_IN !== e2) begin failures++; $display("FAIL shift1_p2 got=%h exp=%h", bus_a.P2_IN, e2); end
        @(negedge clk);
        checks++; if (bus_a.SCAN_DONE !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", bus_a.SCAN_DONE); end
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL shift2_done_timeout got=0 exp=1"); end
        checks++; if (bus_a.P1_IN !== 10'h3FE) begin failures++; $display("FAIL shift2_p1 got=%h exp=3fe", bus_a.P1_IN); end
        checks++; if (bus_a.P2_IN !== 10'h1FF) begin failures++; $display("FAIL shift2_p2 got=%h exp=1ff", bus_a.P2_IN); end
    endtask

    // Zone goes low after edge L+40 (before COMMIT at L+42) for 'hold' cycles
    task automatic test_zone_stall(input int zone, input int hold,
                                   input logic [9:0] np1, input logic [9:0] np2,
                                   input logic [9:0] b1, input logic [9:0] b2,
                                   input logic [9:0] a1, input logic [9:0] a2);
        bit ok;
        int bad;
        pat1 = np1; pat2 = np2;
        wait_latch(ok);
        checks++; if (!ok) begin failures++; $display("FAIL zone%0d_latch_timeout got=0 exp=1", zone); end
        repeat (40) @(negedge clk);
        set_zone(zone, 1'b0);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.P1_IN !== b1 || bus_a.P2_IN !== b2 || bus_a.SCAN_DONE !== 1'b0 || bus_a.BUSY !== 1'b1) begin
                failures++;
                $display("FAIL zone%0d_stall cyc=%0d got p1=%h p2=%h done=%b busy=%b exp p1=%h p2=%h done=0 busy=1",
                         zone, i, bus_a.P1_IN, bus_a.P2_IN, bus_a.SCAN_DONE, bus_a.BUSY, b1, b2);
            end
        end
        set_zone(zone, 1'b1);
        @(negedge clk);
        checks++; if (bus_a.SCAN_DONE !== 1'b1) begin failures++; $display("FAIL zone%0d_done_after_release got=%b exp=1", zone, bus_a.SCAN_DONE); end
        checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL zone%0d_busy_after got=%b exp=0", zone, bus_a.BUSY); end
        checks++; if (bus_a.P1_IN !== a1) begin failures++; $display("FAIL zone%0d_p1 got=%h exp=%h", zone, bus_a.P1_IN, a1); end
        checks++; if (bus_a.P2_IN !== a2) begin failures++; $display("FAIL zone%0d_p2 got=%h exp=%h", zone, bus_a.P2_IN, a2); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int fl, ll, cl, cf, da;
        logic [9:0] e1, e2;
        pat1 = 10'h3FE; pat2 = 10'h1FF;
        e1 = DEB ? 10'h3FF : 10'h3FE;
        e2 = DEB ? 10'h3FF : 10'h1FF;
        wait_latch(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_latch_timeout got=0 exp=1"); end
        repeat (22) @(negedge clk);
        checks++; if (bus_a.PAD_CLK !== 1'b0) begin failures++; $display("FAIL mid_bit5_low got=%b exp=0", bus_a.PAD_CLK); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.PAD_CLK !== 1'b1) begin failures++; $display("FAIL mid_rst_padclk got=%b exp=1", bus_a.PAD_CLK); end
        checks++; if (bus_a.PAD_LATCH !== 1'b0) begin failures++; $display("FAIL mid_rst_latch got=%b exp=0", bus_a.PAD_LATCH); end
        checks++; if (bus_a.P1_IN !== 10'h3FF) begin failures++; $display("FAIL mid_rst_p1 got=%h exp=3ff", bus_a.P1_IN); end
        checks++; if (bus_a.P2_IN !== 10'h3FF) begin failures++; $display("FAIL mid_rst_p2 got=%h exp=3ff", bus_a.P2_IN); end
        checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", bus_a.BUSY); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        observe_from_release(fl, ll, cl, cf, da);
        checks++; if (fl != 201) begin failures++; $display("FAIL resume_latch_edge got=%0d exp=201", fl); end
        checks++; if (cf != 10) begin failures++; $display("FAIL resume_pulses got=%0d exp=10", cf); end
        checks++; if (da != 244) begin failures++; $display("FAIL resume_done_edge got=%0d exp=244", da); end
        checks++; if (bus_a.P1_IN !== e1) begin failures++; $display("FAIL resume_p1 got=%h exp=%h", bus_a.P1_IN, e1); end
        checks++; if (bus_a.P2_IN !== e2) begin failures++; $display("FAIL resume_p2 got=%h exp=%h", bus_a.P2_IN, e2); end
    endtask

    // SCAN_DIV=40: first tick edge 40, scans of 44 cycles chained via pending,
    // so scan k has PAD_LATCH on edges 41+44k..42+44k and SCAN_DONE on 84+44k.
    task automatic test_back_to_back();
        logic el, ed, eb;
        int   ph;
        rst_b_n = 1'b1;
        for (int n = 1; n <= 488; n++) begin
            @(negedge clk);
            ph = (n - 41) % 44;
            el = (n >= 41) && (ph < 2);
            eb = (n >= 41) && (ph < 43);
            ed = (n >= 84) && (((n - 84) % 44) == 0);
            checks++;
            if (bus_b.PAD_LATCH !== el || bus_b.SCAN_DONE !== ed || bus_b.BUSY !== eb) begin
                failures++;
                $display("FAIL b2b edge=%0d got latch=%b done=%b busy=%b exp latch=%b done=%b busy=%b",
                         n, bus_b.PAD_LATCH, bus_b.SCAN_DONE, bus_b.BUSY, el, ed, eb);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        bus_a.nCTRL1_ZONE   = 1'b1;
        bus_a.nCTRL2_ZONE   = 1'b1;
        bus_a.nSTATUSB_ZONE = 1'b1;
        #1;
        rst_n   = 1'b0;
        rst_b_n = 1'b0;

        test_reset();
        test_shift();
        test_zone_stall(1, 30, 10'h3F0, 10'h2FF, 10'h3FE, 10'h1FF,
                        DEB ? 10'h3FE : 10'h3F0, DEB ? 10'h1FF : 10'h2FF);
        test_zone_stall(2, 5, 10'h3F0, 10'h2FF,
                        DEB ? 10'h3FE : 10'h3F0, DEB ? 10'h1FF : 10'h2FF,
                        10'h3F0, 10'h2FF);
        test_zone_stall(3, 5, 10'h3FF, 10'h2FF, 10'h3F0, 10'h2FF,
                        DEB ? 10'h3F0 : 10'h3FF, 10'h2FF);
        test_reset_mid();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
